// File: rtl/pulse_symbol_buffer.sv
// -----------------------------------------------------------------------------
// pulse_symbol_buffer
//
// Small byte-writable word memory with two read paths:
//   * a combinational random-access read port (rd_addr -> rd_data), and
//   * a streaming engine that presents an inclusive address range as a
//     valid/ready symbol stream. The range may wrap through DEPTH-1 to 0 and
//     may optionally repeat forever.
//
// Ports
//   clk, rst_n        single clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data/wr_be
//                     write port; bytes with wr_be[k] set are written
//   rd_addr/rd_data   combinational read of mem[rd_addr]
//   start/stop        begin streaming (in IDLE) / abort streaming
//   loop_en           at end of range, restart from the latched start address
//   start_addr/end_addr
//                     inclusive stream range, captured when the stream starts
//   stream_data/stream_valid/stream_ready/stream_last
//                     symbol stream towards the consumer
//   busy              streaming engine is in RUN
//   done              one-cycle pulse after a stream completes naturally
// -----------------------------------------------------------------------------
module pulse_symbol_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic [AW-1:0]      rd_addr,
  output logic [WIDTH-1:0]   rd_data,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [AW-1:0]      start_addr,
  input  logic [AW-1:0]      end_addr,
  output logic [WIDTH-1:0]   stream_data,
  output logic               stream_valid,
  input  logic               stream_ready,
  output logic               stream_last,
  output logic               busy,
  output logic               done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    // Writes presented while reset is held are dropped.
    if (wr_en && rst_n) begin
      for (int b = 0; b < WIDTH / 8; b++) begin
        if (wr_be[b]) begin
          mem_d[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
        end
      end
    end
  end

  // NOTE: the storage array has no reset branch; clearing it would turn a
  // compact memory into DEPTH*WIDTH resettable flops for no functional gain.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

  // ---------------------------------------------------------------------------
  // Streaming FSM
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] start_q, start_d;
  logic [AW-1:0] end_q, end_d;
  logic          done_q, done_d;

  logic          handshake;
  logic          at_end;

  assign at_end    = (ptr_q == end_q);
  assign handshake = stream_valid && stream_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    start_d = start_q;
    end_d   = end_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // stop wins over a simultaneous start.
        if (start && !stop) begin
          state_d = S_RUN;
          ptr_d   = start_addr;
          start_d = start_addr;
          end_d   = end_addr;
        end
      end
      S_RUN: begin
        // An abort drops the presented word and never reports completion.
        if (stop) begin
          state_d = S_IDLE;
        end else if (handshake) begin
          if (!at_end) begin
            // Natural AW-bit wrap lets a range run through DEPTH-1 to 0.
            ptr_d = ptr_q + AW'(1);
          end else if (loop_en) begin
            ptr_d = start_q;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      start_q <= '0;
      end_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      start_q <= start_d;
      end_q   <= end_d;
      done_q  <= done_d;
    end
  end

  assign busy         = (state_q == S_RUN);
  assign stream_valid = busy;
  assign stream_last  = busy && at_end;
  assign stream_data  = busy ? mem_q[ptr_q] : '0;
  assign done         = done_q;

endmodule

// File: tb/tb_pulse_symbol_buffer.sv
// -----------------------------------------------------------------------------
// tb_pulse_symbol_buffer
//
// Directed bench for pulse_symbol_buffer (WIDTH=32, DEPTH=8). Inputs change
// 1 ns after each rising edge; outputs are compared in the same window,
// well away from the next edge.
// -----------------------------------------------------------------------------
module tb_pulse_symbol_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic               clk;
  logic               rst_n;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic [WIDTH/8-1:0] wr_be;
  logic [AW-1:0]      rd_addr;
  logic [WIDTH-1:0]   rd_data;
  logic               start;
  logic               stop;
  logic               loop_en;
  logic [AW-1:0]      start_addr;
  logic [AW-1:0]      end_addr;
  logic [WIDTH-1:0]   stream_data;
  logic               stream_valid;
  logic               stream_ready;
  logic               stream_last;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;

  pulse_symbol_buffer #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_be        (wr_be),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .start_addr   (start_addr),
    .end_addr     (end_addr),
    .stream_data  (stream_data),
    .stream_valid (stream_valid),
    .stream_ready (stream_ready),
    .stream_last  (stream_last),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    wr_en = 1'b0;
  endtask

  task automatic kick(input logic [AW-1:0] sa, input logic [AW-1:0] ea);
    start = 1'b1; start_addr = sa; end_addr = ea;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_addr = '0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    start_addr = '0; end_addr = '0; stream_ready = 1'b0;

    // Reset state.
    step(); step();
    check("rst_busy",  32'(busy),         32'd0);
    check("rst_valid", 32'(stream_valid), 32'd0);
    check("rst_last",  32'(stream_last),  32'd0);
    check("rst_done",  32'(done),         32'd0);
    check("rst_data",  stream_data,       32'd0);
    rst_n = 1'b1;
    step();

    // Fill and read back.
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), 32'hA0 + 32'(i), 4'hF);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i);
      #1;
      check($sformatf("rd_%0d", i), rd_data, 32'hA0 + 32'(i));
    end

    // Byte-enable write to word 2; old value visible during the write cycle.
    rd_addr = 3'd2;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h11223344; wr_be = 4'h5;
    #1;
    check("wr_old", rd_data, 32'h000000A2);
    step();
    wr_en = 1'b0;
    check("wr_be5", rd_data, 32'h00220044);
    wr(3'd2, 32'hA2, 4'hF);

    // start and stop together in IDLE: nothing starts.
    start = 1'b1; stop = 1'b1; start_addr = 3'd0; end_addr = 3'd7;
    step();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", 32'(busy), 32'd0);

    // Plain stream 2..4, always ready.
    stream_ready = 1'b1; loop_en = 1'b0;
    kick(3'd2, 3'd4);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("s1_data%0d", k), stream_data, 32'hA2 + 32'(k));
      check($sformatf("s1_last%0d", k), 32'(stream_last), (k == 2) ? 32'd1 : 32'd0);
      check($sformatf("s1_valid%0d", k), 32'(stream_valid), 32'd1);
      // start while running must be ignored.
      start = (k == 0); start_addr = 3'd7; end_addr = 3'd7;
      step();
      start = 1'b0;
    end
    check("s1_done", 32'(done), 32'd1);
    check("s1_busy", 32'(busy), 32'd0);
    check("s1_vld0", 32'(stream_valid), 32'd0);
    step();
    check("s1_done_off", 32'(done), 32'd0);

    // Wrapping stream 6..1 with back-pressure on every word.
    stream_ready = 1'b0;
    kick(3'd6, 3'd1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("s2_data%0d", k), stream_data, 32'hA0 + 32'((6 + k) % 8));
      step();
      check($sformatf("s2_hold%0d", k), stream_data, 32'hA0 + 32'((6 + k) % 8));
      check($sformatf("s2_last%0d", k), 32'(stream_last), (k == 3) ? 32'd1 : 32'd0);
      stream_ready = 1'b1;
      step();
      stream_ready = 1'b0;
    end
    check("s2_done", 32'(done), 32'd1);
    check("s2_busy", 32'(busy), 32'd0);

    // Looping single-word stream, then stop.
    stream_ready = 1'b1; loop_en = 1'b1;
    kick(3'd3, 3'd3);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("s3_data%0d", c), stream_data, 32'hA3);
      check($sformatf("s3_last%0d", c), 32'(stream_last), 32'd1);
      check($sformatf("s3_done%0d", c), 32'(done), 32'd0);
      step();
    end
    stop = 1'b1;
    check("s3_busy_pre", 32'(busy), 32'd1);
    step();
    stop = 1'b0;
    check("s3_busy", 32'(busy), 32'd0);
    check("s3_done", 32'(done), 32'd0);
    step();
    check("s3_done2", 32'(done), 32'd0);
    loop_en = 1'b0;

    // Reset during RUN; a write during reset is dropped.
    kick(3'd0, 3'd7);
    step();
    check("s4_pre", stream_data, 32'hA1);
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h0; wr_be = 4'hF;
    step();
    wr_en = 1'b0;
    check("s4_busy",  32'(busy),         32'd0);
    check("s4_valid", 32'(stream_valid), 32'd0);
    check("s4_data",  stream_data,       32'd0);
    check("s4_done",  32'(done),         32'd0);
    rst_n = 1'b1;
    step();
    check("s4_done2", 32'(done), 32'd0);
    kick(3'd5, 3'd6);
    check("s4_d5", stream_data, 32'hA5);
    step();
    check("s4_d6", stream_data, 32'hA6);
    check("s4_last", 32'(stream_last), 32'd1);
    step();
    check("s4_fin", 32'(done), 32'd1);

    // Overwrite the presented word while stalled.
    stream_ready = 1'b0;
    kick(3'd4, 3'd5);
    check("s5_pre", stream_data, 32'hA4);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    #1;
    check("s5_old", stream_data, 32'hA4);
    step();
    wr_en = 1'b0;
    check("s5_new", stream_data, 32'hDEADBEEF);
    stream_ready = 1'b1;
    step();
    check("s5_next", stream_data, 32'hA5);
    step();
    check("s5_done", 32'(done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
